// File: rtl/io_dma_dev.sv
// Bidirectional DMA-style I/O device: two-beat command intake, burst moves between
// the internal buffer and memory, level completion interrupt, sticky busy error.
module io_dma_dev #(
  parameter int SZ    = 8,
  parameter int WSZ   = 8,
  parameter int DEPTH = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_interrupt,
  output logic           tx_interrupt,
  input  logic [SZ-1:0]  addr_in,
  input  logic [WSZ-1:0] data_in,
  output logic [SZ-1:0]  addr_out,
  output logic [WSZ-1:0] data_out,
  output logic           addr_oe,
  output logic           data_oe,
  output logic           w_notr,
  output logic           r_req,
  input  logic           rd_valid,
  output logic           busy,
  output logic           err,
  input  logic           ld_en,
  input  logic [IW-1:0]  ld_idx,
  input  logic [WSZ-1:0] ld_data,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ARM, S_WR, S_RD_REQ, S_RD_WAIT
  } state_t;

  state_t         r_state, w_next;
  logic [IW-1:0]  r_idx;
  logic [SZ-1:0]  r_len;
  logic [SZ-1:0]  r_maddr;
  logic           r_dir;
  logic [WSZ-1:0] r_buf [DEPTH];

  logic w_wr_beat;
  logic w_rd_beat;
  logic w_busy_hit;

  // Memory read handshake: r_req is a one-cycle request; the beat completes on
  // the first rd_valid seen in RD_WAIT, with data_in captured that same edge.
  assign w_wr_beat  = (r_state == S_WR) && (r_len != '0);
  assign w_rd_beat  = (r_state == S_RD_WAIT) && rd_valid;
  assign w_busy_hit = rx_interrupt &&
                      ((r_state == S_WR) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT));

  assign busy      = (r_state != S_IDLE);
  assign addr_oe   = w_notr | r_req;
  assign data_oe   = w_notr;
  assign dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (rx_interrupt) w_next = S_CMD1;
      S_CMD1:    if (rx_interrupt) w_next = S_ARM;
      S_ARM: begin
        if (!rx_interrupt) begin
          if (r_len == '0)  w_next = S_IDLE;
          else if (r_dir)   w_next = S_WR;
          else              w_next = S_RD_REQ;
        end
      end
      // WR lingers one cycle after the last beat so w_notr can drop before IDLE.
      S_WR:      if (r_len == '0) w_next = S_IDLE;
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: if (rd_valid) w_next = (r_len == SZ'(1)) ? S_IDLE : S_RD_REQ;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_maddr      <= '0;
      r_dir        <= 1'b0;
      tx_interrupt <= 1'b0;
      w_notr       <= 1'b0;
      r_req        <= 1'b0;
      err          <= 1'b0;
      addr_out     <= '0;
      data_out     <= '0;
    end else begin
      r_state <= w_next;
      w_notr  <= 1'b0;
      r_req   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_interrupt) begin
            r_idx        <= addr_in[IW-1:0];
            r_len        <= SZ'(data_in);
            tx_interrupt <= 1'b0;
            err          <= 1'b0;
          end
        end
        S_CMD1: begin
          if (rx_interrupt) begin
            r_maddr <= addr_in;
            r_dir   <= data_in[0];
          end
        end
        S_ARM: begin
          if (!rx_interrupt && (r_len == '0)) tx_interrupt <= 1'b1;
        end
        S_RD_REQ: begin
          r_req    <= 1'b1;
          addr_out <= r_maddr;
        end
        default: ;
      endcase
      if (w_wr_beat) begin
        w_notr   <= 1'b1;
        addr_out <= r_maddr;
        data_out <= r_buf[r_idx];
      end
      if (w_wr_beat || w_rd_beat) begin
        r_idx   <= r_idx + IW'(1);
        r_maddr <= r_maddr + SZ'(1);
        r_len   <= r_len - SZ'(1);
        if (r_len == SZ'(1)) tx_interrupt <= 1'b1;
      end
      if (w_busy_hit) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (ld_en && (r_state == S_IDLE)) begin
      r_buf[ld_idx] <= ld_data;
    end else if (w_rd_beat) begin
      r_buf[r_idx] <= data_in;
    end
  end

endmodule

// File: doc/io_dma_dev.md
Name: io_dma_dev

Overview:
- Parametrised DMA-style I/O peripheral; next generation of the single-direction I/O device.
- Accepts a two-beat command from the DMA controller over the shared addr/data bus, signalled by rx_interrupt.
- Moves a burst between its internal buffer and memory in either direction:
  - device->mem: bus writes.
  - mem->device: bus reads with a valid handshake.
- Signals completion with a level tx_interrupt; adds deterministic buffer preload, busy and error reporting.

Parameters:
- SZ, 8, address and length width.
- WSZ, 8, data word width.
- DEPTH, 16, internal buffer entries; power of two, >=2; IW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- rx_interrupt  input  1  command beat valid on addr_in/data_in.
- tx_interrupt  output  1  transfer complete; level.
- addr_in  input  SZ  bus address as seen by device.
- data_in  input  WSZ  bus data as seen by device.
- addr_out  output  SZ  address driven during transfer beats.
- data_out  output  WSZ  write data.
- addr_oe  output  1  equals w_notr | r_req.
- data_oe  output  1  equals w_notr.
- w_notr  output  1  write beat to memory this cycle.
- r_req  output  1  read request to memory this cycle.
- rd_valid  input  1  memory read data valid on data_in.
- busy  output  1  state != IDLE.
- err  output  1  sticky command-while-busy error.
- ld_en  input  1  buffer preload strobe.
- ld_idx  input  IW  preload index.
- ld_data  input  WSZ  preload data.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All outputs 0: tx_interrupt, w_notr, r_req, err, addr_out, data_out.
  - All buffer entries 0.
  - Applies mid-transfer: the in-flight beat is abandoned and no completion is signalled.
- IDLE, rx_interrupt=1 (beat 0):
  - Capture dev_idx = addr_in[IW-1:0] and len = data_in.
  - Clear tx_interrupt and err.
  - Go to CMD1.
- CMD1, rx_interrupt=1 (beat 1):
  - Capture mem_addr = addr_in and dir = data_in[0] (1 = device->mem, 0 = mem->device).
  - Go to ARM.
- CMD1, rx_interrupt=0: hold; no timeout.
- ARM: wait for the first edge with rx_interrupt=0. On that edge:
  - len==0: set tx_interrupt, go to IDLE; no bus beats issued.
  - dir=1: go to WR.
  - dir=0: go to RD_REQ.
- WR, one beat per clock:
  - Register w_notr=1, addr_out=mem_addr, data_out=buf[dev_idx].
  - Then dev_idx+1 (mod DEPTH), mem_addr+1 (mod 2^SZ), len-1.
  - The edge issuing the last beat (len==1) also sets tx_interrupt. The next edge clears w_notr and returns to IDLE.
  - N beats therefore occupy exactly N consecutive cycles of w_notr=1.
- RD_REQ: register r_req=1 for exactly one cycle with addr_out=mem_addr; go to RD_WAIT.
- RD_WAIT:
  - r_req=0; wait for rd_valid=1, no timeout.
  - On rd_valid: buf[dev_idx] <= data_in, advance dev_idx/mem_addr/len as in WR.
  - If len was 1: set tx_interrupt, go to IDLE. Otherwise go to RD_REQ.
  - rd_valid outside RD_WAIT is ignored.
- tx_interrupt stays high until the next accepted beat 0 or reset.
- rx_interrupt=1 in WR, RD_REQ or RD_WAIT:
  - Set err, ignore the beat; the transfer continues unaffected.
  - rx_interrupt in ARM is not an error; ARM simply keeps waiting.
- Wrap-around:
  - dev_idx wraps at DEPTH.
  - mem_addr wraps at 2^SZ.
  - len up to 2^SZ-1 is legal; a burst longer than DEPTH re-reads or overwrites entries modulo DEPTH.
- Preload: ld_en honoured only in IDLE (buf[ld_idx] <= ld_data); ignored otherwise. The same-cycle rx_interrupt beat 0 is also accepted.
- Outputs are registered; no combinational path from inputs to w_notr, r_req or tx_interrupt.

Test Plan:
1. Device->mem:
   - Stimulus: preload buf[0..3] = 11,22,33,44; beat0 (addr=0, data=4); beat1 (addr=0x40, data=1); rx_interrupt low.
   - Required: four consecutive w_notr cycles at 0x40..0x43 with data 11,22,33,44; tx_interrupt rises with the beat at 0x43; busy drops one cycle later.
2. Mem->device, then readback:
   - Stimulus: command (addr=2, data=3), (addr=0x80, data=0); model returns A1, B2, C3 with rd_valid delayed 0, 2 and 5 cycles.
   - Required: r_req pulses at 0x80, 0x81, 0x82, each exactly one cycle; a following device->mem command from index 2 writes A1, B2, C3.
3. Wrap-around:
   - Stimulus: DEPTH=16, start idx 14, len 4, mem_addr 0xFE, write.
   - Required: buffer indices 14, 15, 0, 1 written to addresses 0xFE, 0xFF, 0x00, 0x01.
4. Zero length:
   - Stimulus: len=0 command.
   - Required: no w_notr or r_req; tx_interrupt=1 on the first rx_interrupt-low edge.
5. Busy error:
   - Stimulus: rx_interrupt pulse during WR of len 8; then a new command.
   - Required: err=1; all 8 beats complete correctly; the new beat 0 clears err and tx_interrupt.
6. Reset mid-read:
   - Stimulus: assert rst in RD_WAIT.
   - Required: all outputs 0 immediately; buffer zeroed; after release, a new command executes normally.
